// File: rtl/significand_normalizer.sv
// Post-addition normalize-and-round stage for the decimal32 BCD datapath:
// one-digit right/left normalization per cycle, half-even rounding to 7 digits.
module significand_normalizer #(
    parameter int unsigned EMAX = 191,
    parameter int unsigned EMIN = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] sum_in,
    input  logic [11:0] grs_in,
    input  logic [7:0]  exp_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [27:0] m_out,
    output logic [7:0]  exp_out,
    output logic        inexact,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [8:0] EMAX_9 = 9'(EMAX);
    localparam logic [8:0] EMIN_9 = 9'(EMIN);

    state_t      state_q, state_d;
    logic [43:0] w_q, w_d;
    logic        s_q, s_d;
    logic [8:0]  e_q, e_d;
    logic [27:0] m_q, m_d;
    logic [7:0]  exp_q, exp_d;
    logic        inexact_q, inexact_d;
    logic        overflow_q, overflow_d;

    // Adds one to a 7-digit BCD value; bit 28 is the decimal carry-out.
    function automatic logic [28:0] bcd_inc7(input logic [27:0] v);
        logic [27:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (c) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                    c = 1'b1;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return {c, r};
    endfunction

    logic [3:0]  g_s, r_s, d3_s;
    logic        t_s, round_up_s;
    logic [28:0] inc_s;
    logic [27:0] mant_s;
    logic [8:0]  e_rnd_s;

    // Round decision and rounded significand/exponent from the working register.
    always_comb begin
        g_s        = w_q[11:8];
        r_s        = w_q[7:4];
        d3_s       = w_q[15:12];
        t_s        = (w_q[3:0] != 4'd0) | s_q;
        round_up_s = (g_s > 4'd5) ||
                     ((g_s == 4'd5) && ((r_s != 4'd0) || t_s)) ||
                     ((g_s == 4'd5) && (r_s == 4'd0) && !t_s && d3_s[0]);
        inc_s      = bcd_inc7(w_q[39:12]);
        if (round_up_s && inc_s[28]) begin
            mant_s  = 28'h1000000;
            e_rnd_s = e_q + 9'd1;
        end else if (round_up_s) begin
            mant_s  = inc_s[27:0];
            e_rnd_s = e_q;
        end else begin
            mant_s  = w_q[39:12];
            e_rnd_s = e_q;
        end
    end

    // Next-state and datapath update for the normalize/round sequence.
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        s_d        = s_q;
        e_d        = e_q;
        m_d        = m_q;
        exp_d      = exp_q;
        inexact_d  = inexact_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_d     = {sum_in, grs_in};
                    s_d     = 1'b0;
                    e_d     = {1'b0, exp_in};
                    state_d = NORM;
                end else begin
                    state_d = IDLE;
                end
            end
            NORM: begin
                if (w_q[43:40] != 4'd0) begin
                    w_d = {4'd0, w_q[43:4]};
                    s_d = s_q | (w_q[3:0] != 4'd0);
                    e_d = e_q + 9'd1;
                end else if ((w_q[39:36] == 4'd0) && (w_q != 44'd0) && (e_q > EMIN_9)) begin
                    w_d = {w_q[39:0], 4'd0};
                    e_d = e_q - 9'd1;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                inexact_d = (g_s != 4'd0) || (r_s != 4'd0) || t_s;
                if (e_rnd_s > EMAX_9) begin
                    overflow_d = 1'b1;
                    m_d        = 28'h9999999;
                    exp_d      = EMAX_9[7:0];
                end else begin
                    overflow_d = 1'b0;
                    m_d        = mant_s;
                    exp_d      = e_rnd_s[7:0];
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            w_q        <= 44'd0;
            s_q        <= 1'b0;
            e_q        <= 9'd0;
            m_q        <= 28'd0;
            exp_q      <= 8'd0;
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            s_q        <= s_d;
            e_q        <= e_d;
            m_q        <= m_d;
            exp_q      <= exp_d;
            inexact_q  <= inexact_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign m_out     = m_q;
    assign exp_out   = exp_q;
    assign inexact   = inexact_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_significand_normalizer.sv
// Directed-vector bench for significand_normalizer with an integer-arithmetic
// reference model and a per-cycle output compare process.
module tb_significand_normalizer;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [31:0] sum_in;
    logic [11:0] grs_in;
    logic [7:0]  exp_in;
    logic        out_valid, out_ready;
    logic [27:0] m_out;
    logic [7:0]  exp_out;
    logic        inexact, overflow;

    int checks = 0;
    int failures = 0;

    logic [27:0] exp_m;
    logic [7:0]  exp_e;
    bit          exp_inx, exp_ovf;
    bit          chk_en = 1'b0;

    significand_normalizer #(.EMAX(191), .EMIN(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum_in(sum_in), .grs_in(grs_in), .exp_in(exp_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .m_out(m_out), .exp_out(exp_out),
        .inexact(inexact), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Decimal reference: value as an integer, scale by 10, round half-even on the remainder.
    task automatic model(input logic [31:0] s, input logic [11:0] g, input logic [7:0] ex,
                         output logic [27:0] m, output logic [7:0] eo,
                         output bit inx, output bit ovf, output int n);
        logic [43:0] w;
        longint      val, keep, rem;
        int          e;
        bit          sticky, up;
        w = {s, g};
        val = 0;
        for (int i = 10; i >= 0; i--) val = val * 10 + longint'(w[i*4 +: 4]);
        e = int'(ex);
        n = 0;
        sticky = 1'b0;
        if (val >= 64'd10000000000) begin
            sticky = (val % 10) != 0;
            val = val / 10;
            e++;
            n = 1;
        end else begin
            while (val != 0 && val < 64'd1000000000 && e > 0) begin
                val = val * 10;
                e--;
                n++;
            end
        end
        keep = val / 1000;
        rem  = val % 1000;
        up   = (rem > 500) || (rem == 500 && sticky) || (rem == 500 && !sticky && (keep % 2 == 1));
        inx  = (rem != 0) || sticky;
        if (up) keep++;
        if (keep == 64'd10000000) begin
            keep = 64'd1000000;
            e++;
        end
        ovf = e > 191;
        if (ovf) begin
            m  = 28'h9999999;
            eo = 8'd191;
        end else begin
            m = 28'd0;
            for (int i = 0; i < 7; i++) begin
                m[i*4 +: 4] = 4'(keep % 10);
                keep = keep / 10;
            end
            eo = 8'(e);
        end
    endtask

    // Checks every cycle the result is presented against the expected record.
    always @(negedge clk) begin
        if (!rst && chk_en && out_valid) begin
            chk("m_out", 32'(m_out), 32'(exp_m));
            chk("exp_out", 32'(exp_out), 32'(exp_e));
            chk("inexact", 32'(inexact), 32'(exp_inx));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            chk("in_ready_busy", 32'(in_ready), 32'd0);
        end
    end

    task automatic op(input logic [31:0] s, input logic [11:0] g, input logic [7:0] ex,
                      input logic [27:0] lm, input logic [7:0] le, input bit linx,
                      input bit lovf, input int llat, input int hold);
        int n, lat;
        model(s, g, ex, exp_m, exp_e, exp_inx, exp_ovf, n);
        chk("model_m", 32'(exp_m), 32'(lm));
        chk("model_exp", 32'(exp_e), 32'(le));
        chk("model_flags", {30'd0, exp_inx, exp_ovf}, {30'd0, linx, lovf});
        chk("model_lat", 32'(n + 2), 32'(llat));
        chk_en = 1'b1;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; sum_in = s; grs_in = g; exp_in = ex;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c > 1 || 1'b1) begin
                if (c > 1) begin @(posedge clk); #1; end
                else begin @(posedge clk); #1; end
            end
            if (out_valid) begin lat = c; break; end
        end
        chk("latency", 32'(lat), 32'(n + 2));
        repeat (hold) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        sum_in = 32'd0; grs_in = 12'd0; exp_in = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_outs", {out_valid, inexact, overflow, m_out, exp_out},
            {1'b0, 1'b0, 1'b0, 28'd0, 8'd0});
        @(negedge clk) rst = 1'b0;

        op(32'h01234567, 12'h000, 8'd100, 28'h1234567, 8'd100, 1'b0, 1'b0, 2, 0);
        op(32'h19999999, 12'h000, 8'd100, 28'h2000000, 8'd101, 1'b1, 1'b0, 3, 0);
        op(32'h00000123, 12'h450, 8'd50,  28'h1234500, 8'd46,  1'b0, 1'b0, 6, 1);
        op(32'h01234568, 12'h500, 8'd100, 28'h1234568, 8'd100, 1'b1, 1'b0, 2, 0);
        op(32'h01234567, 12'h500, 8'd100, 28'h1234568, 8'd100, 1'b1, 1'b0, 2, 0);
        op(32'h01234568, 12'h501, 8'd100, 28'h1234569, 8'd100, 1'b1, 1'b0, 2, 0);
        op(32'h00000012, 12'h000, 8'd2,   28'h0001200, 8'd0,   1'b0, 1'b0, 4, 0);
        op(32'h00000000, 12'h000, 8'd77,  28'h0000000, 8'd77,  1'b0, 1'b0, 2, 0);
        op(32'h19999999, 12'h000, 8'd191, 28'h9999999, 8'd191, 1'b1, 1'b1, 3, 5);
        op(32'h09999999, 12'h900, 8'd100, 28'h1000000, 8'd101, 1'b1, 1'b0, 2, 0);
        op(32'h00000001, 12'h000, 8'd5,   28'h0100000, 8'd0,   1'b0, 1'b0, 7, 0);
        op(32'h00000000, 12'h001, 8'd50,  28'h1000000, 8'd41,  1'b0, 1'b0, 11, 0);
        op(32'h12345685, 12'h000, 8'd100, 28'h1234568, 8'd101, 1'b1, 1'b0, 3, 0);
        op(32'h12345685, 12'h001, 8'd100, 28'h1234569, 8'd101, 1'b1, 1'b0, 3, 2);

        // Reset while shifting left must abort without producing a result.
        @(negedge clk);
        in_valid = 1'b1; sum_in = 32'h00000123; grs_in = 12'h450; exp_in = 8'd50;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_outs", {out_valid, inexact, overflow, m_out, exp_out},
            {1'b0, 1'b0, 1'b0, 28'd0, 8'd0});
        @(negedge clk) rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("midrst_no_out", 32'(out_valid), 32'd0);
        end
        op(32'h00000123, 12'h450, 8'd50, 28'h1234500, 8'd46, 1'b0, 1'b0, 6, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
